// File: rtl/cpu_bus_memory_if.sv
// CPU-side bus bundle for cpu_bus_memory.
// Groups the program-load stream, the instruction bus and the data bus.
// Signal prefixes are from the memory's point of view (i_ = into the memory).
//   slave  : the memory (cpu_bus_memory)
//   master : the loader/CPU side driving addresses, write data and load beats
interface cpu_bus_memory_if;
   // program-load stream
   logic        i_load_valid;
   logic        o_load_ready;
   logic [31:0] i_load_data;
   logic        i_load_last;
   // instruction bus
   logic [15:0] i_pc;
   logic [31:0] o_instruction;
   // data bus
   logic [15:0] i_address;
   logic        i_rw;
   logic [31:0] i_data;
   logic [31:0] o_data;

   modport slave (
      input  i_load_valid, i_load_data, i_load_last,
      output o_load_ready,
      input  i_pc,
      output o_instruction,
      input  i_address, i_rw, i_data,
      output o_data
   );

   modport master (
      output i_load_valid, i_load_data, i_load_last,
      input  o_load_ready,
      output i_pc,
      input  o_instruction,
      output i_address, i_rw, i_data,
      input  o_data
   );
endinterface

// File: rtl/cpu_bus_memory.sv
// Unified word RAM serving the CPU instruction and data buses, plus the
// program-load sequencer and two memory-mapped words (host output, halt).
// Ports:
//   i_clk, i_reset     clock and synchronous active-high reset
//   bus                load stream, instruction bus and data bus (slave side)
//   o_cpu_reset_n      active-low reset for the CPU, high only while running
//   o_tohost           last value written to TOHOST_ADDR
//   o_tohost_valid     one-cycle pulse when o_tohost updates
//   o_halted           high once the CPU has written HALT_ADDR
//   o_words_loaded     words accepted during the load (saturates at DEPTH)
module cpu_bus_memory #(
   parameter int unsigned AW          = 10,
   parameter logic [15:0] TOHOST_ADDR = 16'hFFF8,
   parameter logic [15:0] HALT_ADDR   = 16'hFFFC
) (
   input  logic              i_clk,
   input  logic              i_reset,
   cpu_bus_memory_if.slave   bus,
   output logic              o_cpu_reset_n,
   output logic [31:0]       o_tohost,
   output logic              o_tohost_valid,
   output logic              o_halted,
   output logic [AW:0]       o_words_loaded
);

   localparam int unsigned DEPTH     = 1 << AW;
   localparam logic [AW:0] DEPTH_CNT = DEPTH[AW:0];
   localparam logic [AW:0] CNT_ONE   = {{AW{1'b0}}, 1'b1};
   localparam logic [31:0] NOP       = 32'h0000_0000;

   typedef enum logic [1:0] {StLoad, StRun, StHalt} state_e;

   state_e state_q, state_d;

   logic [31:0]   mem [DEPTH];
   logic [AW:0]   words_q;
   logic [31:0]   tohost_q;
   logic          tohost_valid_q;

   logic          load_ready;
   logic          serve_reads;
   logic          load_fire;
   logic          load_store;
   logic          cpu_wr;
   logic          wr_tohost;
   logic          wr_halt;
   logic          wr_ram;
   logic          pc_in_range;
   logic          addr_in_range;
   logic          addr_is_mmio;
   logic [AW-1:0] pc_idx;
   logic [AW-1:0] addr_idx;
   logic          unused_byte_offsets;

   // Address decode: byte offset bits are ignored.
   assign pc_idx        = bus.i_pc[AW+1:2];
   assign addr_idx      = bus.i_address[AW+1:2];
   assign pc_in_range   = (bus.i_pc >> (AW + 2)) == 16'd0;
   assign addr_in_range = (bus.i_address >> (AW + 2)) == 16'd0;
   assign addr_is_mmio  = (bus.i_address == TOHOST_ADDR) || (bus.i_address == HALT_ADDR);
   assign unused_byte_offsets = ^{bus.i_pc[1:0], bus.i_address[1:0]};

   // Reset gates every write so nothing lands in RAM while i_reset is high.
   assign load_fire  = bus.i_load_valid && load_ready && !i_reset;
   assign load_store = load_fire && (words_q < DEPTH_CNT);
   assign cpu_wr     = (state_q == StRun) && bus.i_rw && !i_reset;
   assign wr_tohost  = cpu_wr && (bus.i_address == TOHOST_ADDR);
   assign wr_halt    = cpu_wr && (bus.i_address == HALT_ADDR);
   assign wr_ram     = cpu_wr && addr_in_range && !addr_is_mmio;

   // ---------------- FSM: state register ----------------
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q <= StLoad;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StLoad: if (load_fire && bus.i_load_last) state_d = StRun;
         StRun:  if (wr_halt) state_d = StHalt;
         StHalt: state_d = StHalt;
         default: state_d = StLoad;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   // Decoded straight from the state register, so o_cpu_reset_n rises on the
   // first RUN cycle without any combinational path from the bus inputs.
   always_comb begin
      load_ready    = 1'b0;
      o_cpu_reset_n = 1'b0;
      o_halted      = 1'b0;
      serve_reads   = 1'b0;
      unique case (state_q)
         StLoad: load_ready = 1'b1;
         StRun: begin
            o_cpu_reset_n = 1'b1;
            serve_reads   = 1'b1;
         end
         StHalt: begin
            o_halted    = 1'b1;
            serve_reads = 1'b1;
         end
         default: load_ready = 1'b0;
      endcase
   end

   // Load word counter: doubles as the load write pointer, saturates at DEPTH.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         words_q <= '0;
      end else if (load_fire && (words_q != DEPTH_CNT)) begin
         words_q <= words_q + CNT_ONE;
      end
   end

   // Host-output register and its one-cycle update strobe.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         tohost_q       <= '0;
         tohost_valid_q <= 1'b0;
      end else begin
         tohost_valid_q <= wr_tohost;
         if (wr_tohost) begin
            tohost_q <= bus.i_data;
         end
      end
   end

   // RAM write port; load and CPU writes are exclusive by state.
   always_ff @(posedge i_clk) begin
      if (load_store) begin
         mem[words_q[AW-1:0]] <= bus.i_load_data;
      end else if (wr_ram) begin
         mem[addr_idx] <= bus.i_data;
      end
   end

   // Combinational read ports; a same-cycle write is not yet visible.
   always_comb begin
      bus.o_instruction = NOP;
      if (serve_reads && pc_in_range) begin
         bus.o_instruction = mem[pc_idx];
      end
   end

   always_comb begin
      bus.o_data = 32'h0000_0000;
      if (serve_reads && addr_in_range && !addr_is_mmio) begin
         bus.o_data = mem[addr_idx];
      end
   end

   assign bus.o_load_ready = load_ready;
   assign o_tohost         = tohost_q;
   assign o_tohost_valid   = tohost_valid_q;
   assign o_words_loaded   = words_q;

endmodule

// File: tb/tb_cpu_bus_memory.sv
// Self-checking bench for cpu_bus_memory: expected values are queued as
// stimulus is applied and compared once the outputs have settled.
module tb_cpu_bus_memory;
   localparam int unsigned AW    = 10;
   localparam int unsigned DEPTH = 1 << AW;

   logic          i_clk = 1'b0;
   logic          i_reset;
   logic          o_cpu_reset_n;
   logic [31:0]   o_tohost;
   logic          o_tohost_valid;
   logic          o_halted;
   logic [AW:0]   o_words_loaded;

   cpu_bus_memory_if bus ();

   cpu_bus_memory #(
      .AW          (AW),
      .TOHOST_ADDR (16'hFFF8),
      .HALT_ADDR   (16'hFFFC)
   ) dut (
      .i_clk          (i_clk),
      .i_reset        (i_reset),
      .bus            (bus),
      .o_cpu_reset_n  (o_cpu_reset_n),
      .o_tohost       (o_tohost),
      .o_tohost_valid (o_tohost_valid),
      .o_halted       (o_halted),
      .o_words_loaded (o_words_loaded)
   );

   always #5 i_clk = ~i_clk;

   int checks   = 0;
   int failures = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   typedef enum int {SelInstr, SelData, SelTohost, SelTohostValid, SelHalted,
                     SelCpuResetN, SelLoadReady, SelWords} sel_e;
   typedef struct {
      string       tag;
      sel_e        sel;
      logic [31:0] exp;
   } exp_t;

   exp_t sb[$];

   task automatic expect_out(input string tag, input sel_e sel, input logic [31:0] exp);
      exp_t e;
      e.tag = tag;
      e.sel = sel;
      e.exp = exp;
      sb.push_back(e);
   endtask

   function automatic logic [31:0] observe(input sel_e sel);
      case (sel)
         SelInstr:       return bus.o_instruction;
         SelData:        return bus.o_data;
         SelTohost:      return o_tohost;
         SelTohostValid: return {31'd0, o_tohost_valid};
         SelHalted:      return {31'd0, o_halted};
         SelCpuResetN:   return {31'd0, o_cpu_reset_n};
         SelLoadReady:   return {31'd0, bus.o_load_ready};
         default:        return {{(31-AW){1'b0}}, o_words_loaded};
      endcase
   endfunction

   // Let combinational outputs settle, then pop and compare everything queued.
   task automatic drain();
      exp_t e;
      #2;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         check_eq(e.tag, observe(e.sel), e.exp);
      end
   endtask

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic expect_reset_state(input string pfx);
      expect_out({pfx, "_ready"},   SelLoadReady,   32'd1);
      expect_out({pfx, "_cpurstn"}, SelCpuResetN,   32'd0);
      expect_out({pfx, "_tohost"},  SelTohost,      32'd0);
      expect_out({pfx, "_tv"},      SelTohostValid, 32'd0);
      expect_out({pfx, "_halted"},  SelHalted,      32'd0);
      expect_out({pfx, "_words"},   SelWords,       32'd0);
   endtask

   task automatic cpu_write(input logic [15:0] addr, input logic [31:0] data);
      bus.i_address = addr;
      bus.i_data    = data;
      bus.i_rw      = 1'b1;
      tick();
      bus.i_rw      = 1'b0;
   endtask

   initial begin
      int b;
      int c;
      logic [31:0] beats [3];
      beats[0] = 32'h0100_0010;
      beats[1] = 32'h0200_0020;
      beats[2] = 32'h0300_0030;

      i_reset          = 1'b1;
      bus.i_load_valid = 1'b0;
      bus.i_load_data  = '0;
      bus.i_load_last  = 1'b0;
      bus.i_pc         = '0;
      bus.i_address    = '0;
      bus.i_rw         = 1'b0;
      bus.i_data       = '0;
      tick();
      tick();

      // Reset state; reads return 0 during LOAD.
      expect_reset_state("rst");
      expect_out("rst_instr", SelInstr, 32'd0);
      expect_out("rst_data",  SelData,  32'd0);
      drain();
      i_reset = 1'b0;

      // Three-beat load, valid held high.
      for (int k = 0; k < 3; k++) begin
         bus.i_load_valid = 1'b1;
         bus.i_load_data  = beats[k];
         bus.i_load_last  = (k == 2);
         expect_out("load_ready_hi", SelLoadReady, 32'd1);
         drain();
         tick();
      end
      bus.i_pc = 16'h0008;
      expect_out("load_ready_lo", SelLoadReady, 32'd0);
      expect_out("load_cpurstn",  SelCpuResetN, 32'd1);
      expect_out("load_words",    SelWords,     32'd3);
      expect_out("load_instr8",   SelInstr,     32'h0300_0030);
      drain();
      tick();
      bus.i_pc = 16'h0000;
      expect_out("run_words_hold", SelWords, 32'd3);
      expect_out("load_instr0",    SelInstr, 32'h0100_0010);
      drain();
      bus.i_load_valid = 1'b0;
      bus.i_load_last  = 1'b0;

      // Read-during-write returns old data; new data the cycle after.
      cpu_write(16'h0010, 32'hCAFE_F00D);
      cpu_write(16'h0040, 32'h1111_1111);
      bus.i_address = 16'h0040;
      bus.i_pc      = 16'h0040;
      bus.i_data    = 32'hDEAD_BEEF;
      bus.i_rw      = 1'b1;
      expect_out("rdw_data_old",  SelData,  32'h1111_1111);
      expect_out("rdw_instr_old", SelInstr, 32'h1111_1111);
      drain();
      tick();
      bus.i_rw = 1'b0;
      expect_out("rdw_data_new",  SelData,  32'hDEAD_BEEF);
      expect_out("rdw_instr_new", SelInstr, 32'hDEAD_BEEF);
      drain();
      bus.i_address = 16'h0043;
      expect_out("byte_offset_ignored", SelData, 32'hDEAD_BEEF);
      drain();

      // Host-output register.
      bus.i_address = 16'hFFF8;
      bus.i_data    = 32'h0000_002A;
      bus.i_rw      = 1'b1;
      expect_out("tohost_pre_tv", SelTohostValid, 32'd0);
      drain();
      tick();
      bus.i_rw = 1'b0;
      expect_out("tohost_val",  SelTohost,      32'h0000_002A);
      expect_out("tohost_tv1",  SelTohostValid, 32'd1);
      expect_out("tohost_read", SelData,        32'd0);
      drain();
      tick();
      bus.i_address = 16'h1000;
      bus.i_pc      = 16'h2000;
      expect_out("tohost_tv0",   SelTohostValid, 32'd0);
      expect_out("tohost_hold",  SelTohost,      32'h0000_002A);
      expect_out("oor_data",     SelData,        32'd0);
      expect_out("oor_instr",    SelInstr,       32'd0);
      drain();

      // Halt, then writes are ignored but reads still work.
      cpu_write(16'hFFFC, 32'h0000_0001);
      bus.i_address = 16'h0010;
      bus.i_data    = 32'h0000_0005;
      bus.i_rw      = 1'b1;
      expect_out("halt_flag",    SelHalted,    32'd1);
      expect_out("halt_cpurstn", SelCpuResetN, 32'd0);
      drain();
      tick();
      bus.i_rw = 1'b0;
      bus.i_pc = 16'h0040;
      expect_out("halt_word_kept", SelData,  32'hCAFE_F00D);
      expect_out("halt_instr",     SelInstr, 32'hDEAD_BEEF);
      expect_out("halt_words",     SelWords, 32'd3);
      drain();
      cpu_write(16'hFFF8, 32'h0000_0099);
      expect_out("halt_tohost_kept", SelTohost,      32'h0000_002A);
      expect_out("halt_tohost_tv",   SelTohostValid, 32'd0);
      expect_out("halt_stays",       SelHalted,      32'd1);
      drain();

      // DEPTH+2 beats with valid toggling; idle cycles carry garbage and last=1.
      i_reset = 1'b1;
      tick();
      i_reset = 1'b0;
      b = 0;
      c = 0;
      while (b < int'(DEPTH) + 2) begin
         if ((c % 2) == 0) begin
            bus.i_load_valid = 1'b1;
            bus.i_load_data  = 32'hB000_0000 | b;
            bus.i_load_last  = (b == int'(DEPTH) + 1);
            b++;
         end else begin
            bus.i_load_valid = 1'b0;
            bus.i_load_data  = 32'hFFFF_FFFF;
            bus.i_load_last  = 1'b1;
         end
         tick();
         c++;
         if (c == 4) begin
            expect_out("sat_words_mid", SelWords, 32'd2);
            drain();
         end
      end
      bus.i_load_valid = 1'b0;
      bus.i_load_last  = 1'b0;
      bus.i_pc         = 16'h0000;
      expect_out("sat_words",   SelWords,     DEPTH);
      expect_out("sat_cpurstn", SelCpuResetN, 32'd1);
      expect_out("sat_word0",   SelInstr,     32'hB000_0000);
      drain();
      bus.i_pc = 16'h0FFC;
      expect_out("sat_word_last", SelInstr, 32'hB000_0000 | (DEPTH - 1));
      drain();

      // Reset mid-load, then a fresh single-beat load.
      i_reset = 1'b1;
      tick();
      i_reset = 1'b0;
      bus.i_pc = 16'h0000;
      for (int k = 0; k < 2; k++) begin
         bus.i_load_valid = 1'b1;
         bus.i_load_data  = (k == 0) ? 32'h0000_00AA : 32'h0000_00BB;
         bus.i_load_last  = 1'b0;
         expect_out("mid_load_instr0", SelInstr, 32'd0);
         drain();
         tick();
      end
      bus.i_load_valid = 1'b0;
      i_reset = 1'b1;
      tick();
      expect_reset_state("rst2");
      drain();
      i_reset          = 1'b0;
      bus.i_load_valid = 1'b1;
      bus.i_load_data  = 32'h0000_0077;
      bus.i_load_last  = 1'b1;
      tick();
      bus.i_load_valid = 1'b0;
      bus.i_load_last  = 1'b0;
      expect_out("reload_instr0",  SelInstr,     32'h0000_0077);
      expect_out("reload_words",   SelWords,     32'd1);
      expect_out("reload_cpurstn", SelCpuResetN, 32'd1);
      drain();
      bus.i_pc = 16'h0004;
      expect_out("reload_word1_kept", SelInstr, 32'h0000_00BB);
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/cpu_bus_memory.md
Name: cpu_bus_memory

Overview:
- Responder for both CPU buses: serves the instruction bus (PC in, instruction out) and the data bus (address, rw and write data in, read data out) from one unified word RAM.
- Owns the program-load sequence: holds the CPU in reset while a stream of words is loaded over a valid/ready port, then releases it.
- Decodes two memory-mapped words: a host-output register and a halt trigger. Sits at top level beside the CPU.

Parameters:
- AW, 10, log2 of RAM depth in 32-bit words (DEPTH = 2^AW).
- TOHOST_ADDR, 16'hFFF8, byte address of the host-output register (write-only).
- HALT_ADDR, 16'hFFFC, byte address of the halt trigger (write-only).

Ports:
- i_clk  in  1  clock; all state changes on the rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_load_valid  in  1  load beat valid.
- o_load_ready  out  1  load beat ready; high only in LOAD.
- i_load_data  in  32  load word.
- i_load_last  in  1  marks final load beat; the beat also carries data.
- o_cpu_reset_n  out  1  drives the CPU's active-low reset.
- i_pc  in  16  CPU instruction byte address.
- o_instruction  out  32  instruction at i_pc.
- i_address  in  16  CPU data byte address.
- i_rw  in  1  0 = read, 1 = write.
- i_data  in  32  CPU write data.
- o_data  out  32  read data at i_address.
- o_tohost  out  32  last value written to TOHOST_ADDR.
- o_tohost_valid  out  1  one-cycle pulse when o_tohost updates.
- o_halted  out  1  high in HALT.
- o_words_loaded  out  AW+1  count of words stored during LOAD.

Behaviour:
- Reset values: state LOAD, o_cpu_reset_n=0, o_load_ready=1, o_tohost=0, o_tohost_valid=0, o_halted=0, o_words_loaded=0. RAM contents are not reset.
- Address mapping: word index = addr[AW+1:2]; addr[1:0] are ignored. An address is in range when addr[15:AW+2]==0.
- Read timing: both read ports are combinational (zero latency), as the CPU samples them at the same edge.
- Out-of-range reads return 0 on either port; an out-of-range instruction reads as NOP. Reads of TOHOST_ADDR and HALT_ADDR return 0.
- Writes: synchronous at the rising edge when i_rw=1 and state is RUN.
  - In-range write: updates RAM.
  - TOHOST_ADDR write: o_tohost<=i_data, o_tohost_valid=1 for the next cycle only.
  - HALT_ADDR write: enters HALT next cycle.
  - Any other out-of-range write is dropped.
- Read during write: same-cycle read of a word being written (either port) returns the old contents. New data is visible the following cycle.
- State LOAD:
  - A beat is accepted when i_load_valid && o_load_ready. It writes i_load_data to word index o_words_loaded[AW-1:0] if o_words_loaded<DEPTH.
  - o_words_loaded increments per accepted beat and saturates at DEPTH. Beats beyond DEPTH are accepted and discarded.
  - Accepted beat with i_load_last=1 -> RUN next cycle.
  - Both read ports return 0. CPU data-bus writes are ignored.
- State RUN: o_cpu_reset_n=1, registered, so it rises on the first RUN cycle. o_load_ready=0; load inputs are ignored.
- State HALT: o_halted=1, o_cpu_reset_n=0, and all CPU writes are ignored. Read ports still serve RAM so a debugger can inspect contents. Only i_reset leaves HALT.
- o_words_loaded holds its final value through RUN and HALT.
- Reset mid-load: the load restarts from word 0. RAM words already written keep their data.
- Simultaneous events: i_reset has priority over everything. A halt write and a tohost write cannot coincide (one data bus).

Test Plan:
- Reset, then load 3 beats 0x01000010, 0x02000020, 0x03000030 with last on beat 3, valid held high. -> o_load_ready drops after the beat-3 edge; o_cpu_reset_n=1 the next cycle; o_words_loaded=3; i_pc=0x0008 gives o_instruction=0x03000030.
- In RUN: write 0xDEADBEEF to 0x0040, with i_address=0x0040 in the same cycle and the next. -> o_data is the old value during the write cycle, then 0xDEADBEEF. i_pc=0x0040 also returns 0xDEADBEEF. Address 0x0043 returns the same word.
- In RUN: write 0x0000002A to 0xFFF8. -> o_tohost=0x2A with o_tohost_valid high for exactly 1 cycle. A read of 0xFFF8 returns 0.
- In RUN: write to 0xFFFC, then write 0x5 to 0x0010. -> o_halted=1 and o_cpu_reset_n=0 from the next cycle; word 0x0010 is unchanged; reads still work.
- Load DEPTH+2 beats with i_load_valid toggling each cycle. -> Only valid cycles are accepted; o_words_loaded saturates at DEPTH; word 0 holds beat 0, not beat DEPTH.
- Assert i_reset after 2 load beats. -> All outputs return to reset values and o_words_loaded=0. A new single-beat load (last=1) with 0x77 gives i_pc=0 -> o_instruction=0x77.
